// File: rtl/sevenseg_pkg.sv
// Shared types and glyph table for the multiplexed seven-segment scanner.
// Glyphs are active-high {g,f,e,d,c,b,a}; pin polarity is applied at the top.
package sevenseg_pkg;

    typedef struct packed {
        logic [3:0] value;
        logic       dp;
        logic       blank;
    } digit_cell_t;

    localparam digit_cell_t CELL_RST = '{value: 4'h0, dp: 1'b0, blank: 1'b0};

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] v);
        return SEG_LUT[v];
    endfunction

endpackage

// File: rtl/sevenseg_scan_timer.sv
// Slot timing: free-running tick counter, PWM phase, digit scan index, frame pulse.
// scan_idx advances on the last counter value of each slot; frame_done is the cycle after the wrap.
module sevenseg_scan_timer #(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 65536,
    parameter int BRIGHT_W   = 4,
    localparam int AW        = $clog2(NUM_DIGITS)
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic [BRIGHT_W-1:0] phase,
    output logic [AW-1:0]       scan_idx,
    output logic                frame_done
);

    localparam int            TW       = $clog2(TICK_DIV);
    localparam logic [TW-1:0] CNT_LAST = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(NUM_DIGITS - 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] scan_idx_q, scan_idx_d;
    logic          frame_done_q, frame_done_d;
    logic          slot_tick;

    always_comb begin
        slot_tick    = (cnt_q == CNT_LAST);
        cnt_d        = cnt_q + TW'(1);
        scan_idx_d   = scan_idx_q;
        frame_done_d = 1'b0;
        if (slot_tick) begin
            if (scan_idx_q == IDX_LAST) begin
                scan_idx_d   = '0;
                frame_done_d = 1'b1;
            end else begin
                scan_idx_d = scan_idx_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            scan_idx_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            scan_idx_q   <= scan_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    // PWM phase is the slow end of the counter so each duty step is a contiguous run.
    assign phase      = cnt_q[TW-1 -: BRIGHT_W];
    assign scan_idx   = scan_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment controller: digit register file, leading-zero suppression, PWM.
// Pins are registered: one cycle behind scan_idx/cells; writes show on the second edge.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 65536,
    parameter int BRIGHT_W   = 4,
    parameter bit ACTIVE_LOW = 1'b1,
    localparam int AW        = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    input  logic                  wr_blank,
    input  logic                  clr,
    input  logic [BRIGHT_W-1:0]   brightness,
    input  logic                  lz_blank_en,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [AW-1:0]         scan_idx,
    output logic                  frame_done
);

    digit_cell_t cells_q [NUM_DIGITS];
    digit_cell_t cells_d [NUM_DIGITS];

    logic [BRIGHT_W-1:0] phase;
    logic [AW-1:0]       scan_idx_w;

    logic [NUM_DIGITS-1:0] supp;
    logic                  above_dark;
    digit_cell_t           cur;
    logic                  dark, lit;

    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;

    sevenseg_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .TICK_DIV   (TICK_DIV),
        .BRIGHT_W   (BRIGHT_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .phase      (phase),
        .scan_idx   (scan_idx_w),
        .frame_done (frame_done)
    );

    // Address decode by equality so indices beyond the last digit simply match nothing.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cells_d[i] = cells_q[i];
            if (clr) begin
                cells_d[i] = CELL_RST;
            end else if (wr_en && (wr_addr == AW'(i))) begin
                cells_d[i] = '{value: wr_data, dp: wr_dp, blank: wr_blank};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cells_q[i] <= CELL_RST;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cells_q[i] <= cells_d[i];
            end
        end
    end

    // Walk from the most significant digit down; a zero only hides while everything above is dark.
    always_comb begin
        supp       = '0;
        above_dark = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            supp[i]    = lz_blank_en && (i != 0) && (cells_q[i].value == 4'h0)
                         && !cells_q[i].dp && above_dark;
            above_dark = above_dark && (supp[i] || cells_q[i].blank);
        end
    end

    always_comb begin
        cur     = cells_q[scan_idx_w];
        dark    = cur.blank || supp[scan_idx_w];
        lit     = (&brightness) || (phase < brightness);
        seg_d   = dark ? 7'h00 : hex2seg(cur.value);
        dp_d    = !dark && cur.dp;
        anode_d = '0;
        if (!dark && lit) begin
            anode_d = NUM_DIGITS'(1) << scan_idx_w;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q   <= '0;
            dp_q    <= 1'b0;
            anode_q <= '0;
        end else begin
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            anode_q <= anode_d;
        end
    end

    // Flops hold active-high intent; polarity is a constant inversion on the way out.
    assign segments = seg_q ^ {7{ACTIVE_LOW}};
    assign dp       = dp_q ^ ACTIVE_LOW;
    assign anode    = anode_q ^ {NUM_DIGITS{ACTIVE_LOW}};
    assign scan_idx = scan_idx_w;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl: 4-digit instance plus a 5-digit one for address range.
module tb_sevenseg_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en, wr_dp, wr_blank, clr, lz_blank_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic [1:0] brightness;
    logic [6:0] segments;
    logic       dp, frame_done;
    logic [3:0] anode;
    logic [1:0] scan_idx;

    logic       wr_en2;
    logic [2:0] wr_addr2;
    logic [6:0] segments2;
    logic       dp2, frame_done2;
    logic [4:0] anode2;
    logic [2:0] scan_idx2;

    always #5 clk = ~clk;

    sevenseg_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(16), .BRIGHT_W(2), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_dp(wr_dp), .wr_blank(wr_blank), .clr(clr), .brightness(brightness),
        .lz_blank_en(lz_blank_en), .segments(segments), .dp(dp), .anode(anode),
        .scan_idx(scan_idx), .frame_done(frame_done)
    );

    sevenseg_scan_ctrl #(.NUM_DIGITS(5), .TICK_DIV(16), .BRIGHT_W(2), .ACTIVE_LOW(1'b1)) dut5 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data),
        .wr_dp(wr_dp), .wr_blank(wr_blank), .clr(clr), .brightness(brightness),
        .lz_blank_en(lz_blank_en), .segments(segments2), .dp(dp2), .anode(anode2),
        .scan_idx(scan_idx2), .frame_done(frame_done2)
    );

    typedef struct packed {
        logic [15:0] vals;   // {d3,d2,d1,d0}
        logic [3:0]  dps;
        logic [3:0]  blks;
        logic [1:0]  br;
        logic        lz;
        logic [27:0] segs;   // expected active-low glyph per digit, d3 in the top bits
        logic [3:0]  dpx;    // expected dp pin per digit
        logic [19:0] ons;    // expected lit cycles per 16-cycle slot
    } vec_t;

    vec_t vt [10];

    int n_checks = 0;
    int n_fail   = 0;

    int         on_cnt   [4];
    logic [6:0] seg_seen [4];
    logic       dp_seen  [4];
    logic       seen     [4];
    int         seg_var, onehot_bad;

    function automatic vec_t mk(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                                input logic [1:0] br, input logic lz, input logic [27:0] s,
                                input logic [3:0] dx, input logic [19:0] on);
        vec_t r;
        r.vals = v; r.dps = d; r.blks = b; r.br = br; r.lz = lz;
        r.segs = s; r.dpx = dx; r.ons = on;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_cell(input logic [1:0] a, input logic [3:0] v, input logic d, input logic b);
        wr_en = 1'b1; wr_addr = a; wr_data = v; wr_dp = d; wr_blank = b;
        cyc();
        wr_en = 1'b0;
    endtask

    // Any 64 consecutive output cycles cover every digit slot at every counter value once.
    task automatic observe();
        logic [1:0] prev;
        logic [3:0] exp_an;
        int d;
        for (int i = 0; i < 4; i++) begin
            on_cnt[i] = 0; seen[i] = 1'b0; seg_seen[i] = '0; dp_seen[i] = 1'b0;
        end
        seg_var = 0; onehot_bad = 0;
        prev = scan_idx;
        repeat (64) begin
            cyc();
            d      = int'(prev);
            exp_an = ~(4'b0001 << prev);
            if (anode == exp_an) on_cnt[d]++;
            else if (anode != 4'hF) onehot_bad++;
            if (!seen[d]) begin
                seen[d] = 1'b1; seg_seen[d] = segments; dp_seen[d] = dp;
            end else if (segments != seg_seen[d] || dp != dp_seen[d]) begin
                seg_var++;
            end
            prev = scan_idx;
        end
    endtask

    initial begin
        int k, pulses, first, second, bad, cnt;
        logic [1:0] prev_i;

        vt[0] = mk(16'h4321, 4'b0000, 4'b0000, 2'd3, 1'b0, {7'h19, 7'h30, 7'h24, 7'h79}, 4'hF, {5'd16, 5'd16, 5'd16, 5'd16});
        vt[1] = mk(16'h4321, 4'b0000, 4'b0000, 2'd1, 1'b0, {7'h19, 7'h30, 7'h24, 7'h79}, 4'hF, {5'd4, 5'd4, 5'd4, 5'd4});
        vt[2] = mk(16'h4321, 4'b0000, 4'b0000, 2'd0, 1'b0, {7'h19, 7'h30, 7'h24, 7'h79}, 4'hF, {5'd0, 5'd0, 5'd0, 5'd0});
        vt[3] = mk(16'h0050, 4'b0000, 4'b0000, 2'd3, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF, {5'd0, 5'd0, 5'd16, 5'd16});
        vt[4] = mk(16'h0050, 4'b1000, 4'b0000, 2'd3, 1'b1, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b0111, {5'd16, 5'd16, 5'd16, 5'd16});
        vt[5] = mk(16'h4321, 4'b0000, 4'b0100, 2'd3, 1'b0, {7'h19, 7'h7F, 7'h24, 7'h79}, 4'hF, {5'd16, 5'd0, 5'd16, 5'd16});
        vt[6] = mk(16'h8007, 4'b0000, 4'b1000, 2'd3, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'hF, {5'd0, 5'd0, 5'd0, 5'd16});
        vt[7] = mk(16'h9000, 4'b0000, 4'b0000, 2'd3, 1'b1, {7'h10, 7'h40, 7'h40, 7'h40}, 4'hF, {5'd16, 5'd16, 5'd16, 5'd16});
        vt[8] = mk(16'hDCBA, 4'b0000, 4'b0000, 2'd2, 1'b0, {7'h21, 7'h46, 7'h03, 7'h08}, 4'hF, {5'd8, 5'd8, 5'd8, 5'd8});
        vt[9] = mk(16'h68FE, 4'b0000, 4'b0000, 2'd3, 1'b0, {7'h02, 7'h00, 7'h0E, 7'h06}, 4'hF, {5'd16, 5'd16, 5'd16, 5'd16});

        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_dp = 1'b0; wr_blank = 1'b0;
        clr = 1'b0; brightness = 2'd3; lz_blank_en = 1'b0; wr_en2 = 1'b0; wr_addr2 = '0;

        // Reset state and first slot after release.
        repeat (3) @(negedge clk);
        check("rst anode", anode, 4'hF);
        check("rst segments", segments, 7'h7F);
        check("rst dp", dp, 1'b1);
        check("rst scan_idx", scan_idx, 2'd0);
        check("rst frame_done", frame_done, 1'b0);
        reset_n = 1'b1;
        cyc();
        check("post-rst anode", anode, 4'b1110);
        check("post-rst segments", segments, 7'h40);
        check("post-rst scan_idx", scan_idx, 2'd0);

        for (int v = 0; v < 10; v++) begin
            brightness  = vt[v].br;
            lz_blank_en = vt[v].lz;
            for (int i = 0; i < 4; i++) begin
                write_cell(2'(i), vt[v].vals[4*i +: 4], vt[v].dps[i], vt[v].blks[i]);
            end
            cyc();
            observe();
            for (int i = 0; i < 4; i++) begin
                check($sformatf("vec%0d d%0d segments", v, i), seg_seen[i], vt[v].segs[7*i +: 7]);
                check($sformatf("vec%0d d%0d lit cycles", v, i), on_cnt[i], vt[v].ons[5*i +: 5]);
                check($sformatf("vec%0d d%0d dp", v, i), dp_seen[i], vt[v].dpx[i]);
            end
            check($sformatf("vec%0d anode one-hot", v), onehot_bad, 0);
            check($sformatf("vec%0d segments steady in slot", v), seg_var, 0);
        end

        // frame_done: one pulse per 64 cycles, right after the 3 -> 0 wrap.
        brightness = 2'd3; lz_blank_en = 1'b0;
        pulses = 0; first = -1; second = -1; bad = 0;
        prev_i = scan_idx;
        for (int c = 0; c < 128; c++) begin
            cyc();
            if (frame_done) begin
                pulses++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
                if (!(scan_idx == 2'd0 && prev_i == 2'd3)) bad++;
            end
            prev_i = scan_idx;
        end
        check("frame_done pulse count", pulses, 2);
        check("frame_done period", second - first, 64);
        check("frame_done at wrap", bad, 0);

        // clr beats a same-cycle write.
        clr = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h9; wr_dp = 1'b0; wr_blank = 1'b0;
        cyc();
        clr = 1'b0; wr_en = 1'b0;
        cyc();
        observe();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("clr d%0d segments", i), seg_seen[i], 7'h40);
        end

        // Live write to the digit being shown, mid-slot.
        k = 0;
        while (scan_idx == 2'd2 && k < 100) begin cyc(); k++; end
        while (scan_idx != 2'd2 && k < 100) begin cyc(); k++; end
        check("live wait for digit 2", (k < 100) ? 1 : 0, 1);
        repeat (5) cyc();
        write_cell(2'd2, 4'hA, 1'b0, 1'b0);
        check("live 1 edge segments", segments, 7'h40);
        check("live 1 edge anode", anode, 4'b1011);
        cyc();
        check("live 2 edges segments", segments, 7'h08);
        check("live 2 edges anode", anode, 4'b1011);
        brightness = 2'd0;
        cyc();
        check("brightness 0 immediate", anode, 4'hF);
        brightness = 2'd3;
        cyc();
        check("brightness 3 immediate", anode, 4'b1011);

        // Reset asserted mid-scan acts immediately and clears the cells.
        #2 reset_n = 1'b0;
        #1;
        check("mid rst anode", anode, 4'hF);
        check("mid rst segments", segments, 7'h7F);
        check("mid rst dp", dp, 1'b1);
        check("mid rst scan_idx", scan_idx, 2'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        check("mid post-rst anode", anode, 4'b1110);
        check("mid post-rst segments", segments, 7'h40);
        observe();
        check("mid post-rst d2 cleared", seg_seen[2], 7'h40);

        // Out-of-range write on the 5-digit instance changes nothing; in-range does.
        wr_en2 = 1'b1; wr_addr2 = 3'd5; wr_data = 4'h8;
        cyc();
        wr_en2 = 1'b0;
        cyc();
        cnt = 0;
        repeat (80) begin cyc(); if (segments2 != 7'h40) cnt++; end
        check("addr 5 ignored", cnt, 0);
        wr_en2 = 1'b1; wr_addr2 = 3'd4; wr_data = 4'h1;
        cyc();
        wr_en2 = 1'b0;
        cyc();
        cnt = 0;
        repeat (80) begin cyc(); if (segments2 == 7'h79) cnt++; end
        check("addr 4 written", cnt, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
